// File: rtl/sdram_cpu_seq.sv
// CPU-side request sequencer for the 6-state SDRAM cycle controller: turns a level
// req/ack handshake into slot-aligned oe/we strobes. Optional: SDRAM_CPU_SEQ_POSTED_WRITE_EN.
module sdram_cpu_seq #(
  parameter int SLOT_CLKS = 6,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        init,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        busy,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout
);

  typedef enum logic [1:0] {IDLE, STROBE, RELEASE, CAPTURE} state_t;

  // Each phase lasts SLOT_CLKS+1 clocks so it always spans one controller q==0 sample.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_CLKS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op;

  always_ff @(posedge clk) begin
    if (init) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= 1'b0;
      sd_oe    <= 1'b0;
      sd_we    <= 1'b0;
      cpu_ack  <= 1'b0;
      busy     <= 1'b0;
      cpu_dout <= 8'h00;
      sd_addr  <= '0;
      sd_din   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      cnt     <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          sd_oe <= 1'b0;
          sd_we <= 1'b0;
          if (cpu_req) begin
            sd_addr <= cpu_addr;
            sd_din  <= cpu_din;
            op      <= cpu_we;
            busy    <= 1'b1;
            cnt     <= '0;
            state   <= STROBE;
          end
        end
        STROBE: begin
          sd_oe <= ~op;
          sd_we <= op;
`ifdef SDRAM_CPU_SEQ_POSTED_WRITE_EN
          // Posted write: release the CPU on the first strobe clock, keep running.
          if (op && cnt == '0) cpu_ack <= 1'b1;
`endif
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          sd_oe <= 1'b0;
          sd_we <= 1'b0;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!op) cpu_dout <= sd_dout;
`ifdef SDRAM_CPU_SEQ_POSTED_WRITE_EN
          cpu_ack <= ~op;
`else
          cpu_ack <= 1'b1;
`endif
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          sd_oe <= 1'b0;
          sd_we <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
